// File: rtl/rgmii_phy_ctrl.sv
// RGMII link/speed controller: polls the PHY status register over the MDIO
// command/response streams, tracks link and speed, and holds the MAC in reset across changes.
module rgmii_phy_ctrl #(
    parameter logic [4:0] PHY_ADDR    = 5'd0,
    parameter logic [4:0] STAT_REG    = 5'h11,
    parameter int         LINK_BIT    = 10,
    parameter int         SPEED_LSB   = 14,
    parameter int         POLL_PERIOD = 1250000,
    parameter int         TIMEOUT     = 65536,
    parameter int         RST_CYCLES  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        poll_now,
    input  logic        force_en,
    input  logic [1:0]  force_speed,
    output logic [4:0]  cmd_phy_addr,
    output logic [4:0]  cmd_reg_addr,
    output logic [15:0] cmd_data,
    output logic [1:0]  cmd_opcode,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    input  logic [15:0] data_out,
    input  logic        data_out_valid,
    output logic        data_out_ready,
    output logic [1:0]  speed,
    output logic        link_up,
    output logic        mac_rst,
    output logic        status_change,
    output logic        timeout_err,
    output logic [7:0]  err_count
);

    localparam int TW = (POLL_PERIOD > 2) ? $clog2(POLL_PERIOD) : 1;
    localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int AW = (RST_CYCLES > 2) ? $clog2(RST_CYCLES) : 1;

    localparam logic [TW-1:0] TIMER_LOAD = TW'(POLL_PERIOD - 1);
    localparam logic [WW-1:0] WAIT_MAX   = WW'(TIMEOUT - 1);
    localparam logic [AW-1:0] APPLY_MAX  = AW'(RST_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, CMD, RESP, APPLY} state_t;

    state_t        state, state_n;
    logic [TW-1:0] timer;
    logic [WW-1:0] wcnt;
    logic [AW-1:0] acnt;
    logic          first_poll;
    logic          nl_q;
    logic [1:0]    ns_q;

    logic          nl;
    logic [1:0]    raw_speed;
    logic [1:0]    ns;
    logic          timeout;
    logic          reserved;

    assign cmd_phy_addr = PHY_ADDR;
    assign cmd_reg_addr = STAT_REG;
    assign cmd_data     = 16'h0000;
    assign cmd_opcode   = 2'b10;
    assign cmd_valid    = (state == CMD);
    assign mac_rst      = (state == APPLY) || !link_up;

    // Only the link and speed bits matter; the rest of the PHY word is dropped.
    logic unused_data;
    assign unused_data = ^data_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        timeout   = 1'b0;
        reserved  = 1'b0;
        nl        = data_out[LINK_BIT];
        raw_speed = data_out[SPEED_LSB+1:SPEED_LSB];
        ns        = force_en ? force_speed : raw_speed;
        case (state)
            IDLE: begin
                if (timer == '0 || poll_now) state_n = CMD;
            end
            CMD: begin
                if (cmd_ready) begin
                    state_n = RESP;
                end else if (wcnt == WAIT_MAX) begin
                    timeout = 1'b1;
                    state_n = IDLE;
                end
            end
            RESP: begin
                if (data_out_valid) begin
                    if (nl && raw_speed == 2'b11 && !force_en) begin
                        reserved = 1'b1;
                        state_n  = IDLE;
                    end else if (first_poll || nl != link_up || (nl && ns != speed)) begin
                        state_n = APPLY;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (wcnt == WAIT_MAX) begin
                    timeout = 1'b1;
                    state_n = IDLE;
                end
            end
            APPLY: begin
                if (acnt == APPLY_MAX) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer          <= '0;
            wcnt           <= '0;
            acnt           <= '0;
            first_poll     <= 1'b1;
            nl_q           <= 1'b0;
            ns_q           <= 2'b10;
            speed          <= 2'b10;
            link_up        <= 1'b0;
            data_out_ready <= 1'b0;
            status_change  <= 1'b0;
            timeout_err    <= 1'b0;
            err_count      <= '0;
        end else begin
            // Always ready so stale responses outside RESP drain harmlessly.
            data_out_ready <= 1'b1;
            status_change  <= 1'b0;
            timeout_err    <= timeout;

            if ((timeout || reserved) && err_count != 8'hFF)
                err_count <= err_count + 8'd1;

            if (state != IDLE && state_n == IDLE)
                timer <= TIMER_LOAD;
            else if (state == IDLE && timer != '0)
                timer <= timer - TW'(1);

            if (state_n != state)
                wcnt <= '0;
            else if (state == CMD || state == RESP)
                wcnt <= wcnt + WW'(1);

            if (state == APPLY && state_n == APPLY)
                acnt <= acnt + AW'(1);
            else
                acnt <= '0;

            if (state == RESP && data_out_valid) begin
                nl_q <= nl;
                ns_q <= ns;
            end

            if (state == APPLY) begin
                // A link-down result keeps the last good speed on the interface.
                if (acnt == '0 && nl_q) speed <= ns_q;
                if (state_n == IDLE) begin
                    link_up       <= nl_q;
                    first_poll    <= 1'b0;
                    status_change <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rgmii_phy_ctrl.sv
// Scoreboard bench for rgmii_phy_ctrl: directed PHY responses, expected events
// queued by the stimulus and matched by a negedge monitor.
module tb_rgmii_phy_ctrl;

    localparam int         PP = 64;
    localparam int         TO = 32;
    localparam int         RC = 16;
    localparam logic [4:0] PA = 5'd3;
    localparam logic [4:0] SR = 5'h11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        poll_now = 1'b0;
    logic        force_en = 1'b0;
    logic [1:0]  force_speed = 2'b00;
    logic [4:0]  cmd_phy_addr;
    logic [4:0]  cmd_reg_addr;
    logic [15:0] cmd_data;
    logic [1:0]  cmd_opcode;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [15:0] data_out = 16'h0000;
    logic        data_out_valid = 1'b0;
    logic        data_out_ready;
    logic [1:0]  speed;
    logic        link_up;
    logic        mac_rst;
    logic        status_change;
    logic        timeout_err;
    logic [7:0]  err_count;

    rgmii_phy_ctrl #(
        .PHY_ADDR(PA), .STAT_REG(SR), .LINK_BIT(10), .SPEED_LSB(14),
        .POLL_PERIOD(PP), .TIMEOUT(TO), .RST_CYCLES(RC)
    ) dut (
        .clk(clk), .rst(rst), .poll_now(poll_now), .force_en(force_en),
        .force_speed(force_speed), .cmd_phy_addr(cmd_phy_addr),
        .cmd_reg_addr(cmd_reg_addr), .cmd_data(cmd_data), .cmd_opcode(cmd_opcode),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .data_out(data_out),
        .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
        .speed(speed), .link_up(link_up), .mac_rst(mac_rst),
        .status_change(status_change), .timeout_err(timeout_err),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_CMD, EV_STAT, EV_TO} ev_e;
    typedef struct {
        ev_e        kind;
        logic       link;
        logic [1:0] spd;
        logic [7:0] errc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input ev_e k, input logic l, input logic [1:0] s, input logic [7:0] e);
        exp_t x;
        x.kind = k; x.link = l; x.spd = s; x.errc = e;
        q.push_back(x);
    endtask

    task automatic mon(input ev_e k);
        exp_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d expected none", k);
            return;
        end
        e = q.pop_front();
        chk("event_kind", k, e.kind);
        case (k)
            EV_CMD: begin
                chk("cmd_phy_addr", cmd_phy_addr, PA);
                chk("cmd_reg_addr", cmd_reg_addr, SR);
                chk("cmd_opcode", cmd_opcode, 2'b10);
                chk("cmd_data", cmd_data, 16'h0000);
            end
            EV_STAT: begin
                chk("stat_link_up", link_up, e.link);
                chk("stat_speed", speed, e.spd);
            end
            default: chk("to_err_count", err_count, e.errc);
        endcase
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (cmd_valid && cmd_ready) mon(EV_CMD);
            if (status_change)          mon(EV_STAT);
            if (timeout_err)            mon(EV_TO);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cmd(output int n);
        n = 0;
        while (!cmd_valid && n < 1000) begin tick(); n++; end
        if (!cmd_valid) chk("cmd_wait_expired", 0, 1);
    endtask

    // One MDIO read: accept the command, answer on the following cycle.
    task automatic serve(input logic [15:0] d);
        int n;
        push(EV_CMD, 1'b0, 2'b00, 8'd0);
        wait_cmd(n);
        if (!cmd_valid) return;
        cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
        data_out = d; data_out_valid = 1'b1; tick(); data_out_valid = 1'b0;
    endtask

    task automatic wait_mac_low(output int n);
        n = 0;
        while (mac_rst && n < 200) begin tick(); n++; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        repeat (3) tick();
        chk("rst_cmd_valid", cmd_valid, 1'b0);
        chk("rst_data_out_ready", data_out_ready, 1'b0);
        chk("rst_mac_rst", mac_rst, 1'b1);
        chk("rst_speed", speed, 2'b10);
        chk("rst_link_up", link_up, 1'b0);
        chk("rst_err_count", err_count, 8'd0);
        chk("rst_status_change", status_change, 1'b0);
        chk("rst_timeout_err", timeout_err, 1'b0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", data_out_ready, 1'b1);
        chk("first_poll_latency", cmd_valid, 1'b1);

        // 1G link up on the first poll
        serve(16'h8400);
        push(EV_STAT, 1'b1, 2'b10, 8'd0);
        chk("t1_mac_rst_apply", mac_rst, 1'b1);
        wait_mac_low(n);
        chk("t1_mac_rst_len", n, RC);
        chk("t1_link_up", link_up, 1'b1);
        chk("t1_speed", speed, 2'b10);
        wait_cmd(n);
        chk("t1_poll_period", n, PP);

        // same status again: no apply
        serve(16'h8400);
        tick();
        chk("t2_nochange_mac_rst", mac_rst, 1'b0);

        // speed change to 100M
        serve(16'h4400);
        push(EV_STAT, 1'b1, 2'b01, 8'd0);
        wait_mac_low(n);
        chk("t2_mac_rst_len", n, RC);
        chk("t2_speed", speed, 2'b01);
        wait_cmd(n);
        chk("t2_poll_period", n, PP);

        // link down: speed held, MAC stays in reset
        serve(16'h0000);
        push(EV_STAT, 1'b0, 2'b01, 8'd0);
        repeat (RC) tick();
        chk("t3_link_up", link_up, 1'b0);
        chk("t3_speed_held", speed, 2'b01);
        chk("t3_mac_rst", mac_rst, 1'b1);
        repeat (30) tick();
        chk("t3_mac_rst_wait", mac_rst, 1'b1);
        serve(16'h4400);
        push(EV_STAT, 1'b1, 2'b01, 8'd0);
        wait_mac_low(n);
        chk("t3_relink_len", n, RC);
        chk("t3_relink_up", link_up, 1'b1);

        // command never accepted
        wait_cmd(n);
        push(EV_TO, 1'b0, 2'b00, 8'd1);
        n = 0;
        while (!timeout_err && n < 200) begin tick(); n++; end
        chk("t4_timeout_len", n, TO);
        chk("t4_err_count", err_count, 8'd1);
        wait_cmd(n);
        chk("t4_retry_period", n, PP);
        serve(16'h4400);

        // forced speed, then reserved speed code
        force_en = 1'b1; force_speed = 2'b00;
        serve(16'h8400);
        force_en = 1'b0;
        push(EV_STAT, 1'b1, 2'b00, 8'd1);
        wait_mac_low(n);
        chk("t5_force_len", n, RC);
        chk("t5_force_speed", speed, 2'b00);
        serve(16'hC400);
        tick();
        chk("t5_rsv_err_count", err_count, 8'd2);
        chk("t5_rsv_speed", speed, 2'b00);
        chk("t5_rsv_link", link_up, 1'b1);
        chk("t5_rsv_mac_rst", mac_rst, 1'b0);

        // poll_now from IDLE, then async reset during RESP
        repeat (5) tick();
        chk("t6_idle_before", cmd_valid, 1'b0);
        poll_now = 1'b1; tick(); poll_now = 1'b0;
        chk("t6_poll_now", cmd_valid, 1'b1);
        push(EV_CMD, 1'b0, 2'b00, 8'd0);
        cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_cmd_valid", cmd_valid, 1'b0);
        chk("t6_rst_speed", speed, 2'b10);
        chk("t6_rst_link_up", link_up, 1'b0);
        chk("t6_rst_mac_rst", mac_rst, 1'b1);
        chk("t6_rst_err_count", err_count, 8'd0);
        chk("t6_rst_ready", data_out_ready, 1'b0);
        tick();
        rst = 1'b0;
        data_out = 16'h0000; data_out_valid = 1'b1; tick(); data_out_valid = 1'b0;
        serve(16'h8400);
        push(EV_STAT, 1'b1, 2'b10, 8'd0);
        wait_mac_low(n);
        chk("t6_after_rst_len", n, RC);
        chk("t6_after_rst_link", link_up, 1'b1);

        repeat (3) tick();
        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
